des_key_schedule_responder: RTL and testbench

DES_KEY_SCHEDULE_RESPONDER -- requirements
Module: des_key_schedule_responder

---
 rtl/des_key_schedule_responder_if.sv | 34 +++
 rtl/des_key_schedule_responder.sv | 196 +++++++++++++++++++
 tb/tb_des_key_schedule_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_responder_if.sv
// ============================================================================
// Module      : des_key_schedule_responder_if
// Description : Bundle of the key-load and subkey request/response signals
//               that connect a round controller to the DES key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_key_schedule_responder_if;
   logic        load_key;
   logic [63:0] key;
   logic        subkey_req;
   logic [4:0]  round_counter;
   logic        mode;
   logic        keys_ready;
   logic        busy;
   logic        subkey_valid;
   logic [47:0] subkey;
   logic        subkey_err;

   // Round controller side
   modport master (
      output load_key, key, subkey_req, round_counter, mode,
      input  keys_ready, busy, subkey_valid, subkey, subkey_err
   );

   // Key schedule side
   modport slave (
      input  load_key, key, subkey_req, round_counter, mode,
      output keys_ready, busy, subkey_valid, subkey, subkey_err
   );
endinterface

`default_nettype wire

// File: rtl/des_key_schedule_responder.sv
// ============================================================================
// Module      : des_key_schedule_responder
// Description : Computes the 16 DES round subkeys from a 64-bit key into a
//               register buffer, then answers single-cycle subkey requests
//               (encrypt or decrypt order). Requests arriving while the
//               schedule is not ready are held in a one-entry pending slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_schedule_responder (
   input  logic                          clk,
   input  logic                          rst_n,
   des_key_schedule_responder_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PC1   = 2'd1,
      S_GEN   = 2'd2,
      S_READY = 2'd3
   } state_t;

   // Permuted choice tables, DES 1-based bit numbers, first entry = output MSB
   localparam logic [335:0] c_pc1_tab = {
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [287:0] c_pc2_tab = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   // DES bit n of the key sits at key[64-n], i.e. index ~(n-1) in 6 bits
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      logic [5:0]  n;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         n = c_pc1_tab[335 - 6*i -: 6];
         r = {r[54:0], k[~(n - 6'd1)]};
      end
      return r;
   endfunction

   // DES bit n of the C:D pair sits at cd[56-n]
   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      logic [5:0]  n;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         n = c_pc2_tab[287 - 6*i -: 6];
         r = {r[46:0], cd[6'd56 - n]};
      end
      return r;
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction

   state_t      r_state;
   logic [63:0] r_key;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [47:0] r_buf [16];
   logic [3:0]  r_gen_idx;
   logic        r_keys_ready;
   logic        r_busy;
   logic        r_valid;
   logic [47:0] r_subkey;
   logic        r_err;
   logic        r_pend_valid;
   logic [4:0]  r_pend_rc;
   logic        r_pend_mode;

   logic        w_accept_load;
   logic        w_rot_two;
   logic [27:0] w_c_rot;
   logic [27:0] w_d_rot;
   logic        w_resp_go;
   logic [4:0]  w_resp_rc;
   logic        w_resp_mode;
   logic [3:0]  w_eff_idx;

   // Rotation amount, load acceptance and selection of the request to answer;
   // a live request in READY wins over the pending one
   always_comb begin
      w_accept_load = bus.load_key && (r_state == S_IDLE || r_state == S_READY);
      w_rot_two     = !(r_gen_idx == 4'd0 || r_gen_idx == 4'd1 ||
                        r_gen_idx == 4'd8 || r_gen_idx == 4'd15);
      w_c_rot       = rotl(r_c, w_rot_two);
      w_d_rot       = rotl(r_d, w_rot_two);
      w_resp_go     = 1'b0;
      w_resp_rc     = r_pend_rc;
      w_resp_mode   = r_pend_mode;
      if (r_state == S_READY && !bus.load_key) begin
         if (bus.subkey_req) begin
            w_resp_go   = 1'b1;
            w_resp_rc   = bus.round_counter;
            w_resp_mode = bus.mode;
         end else if (r_pend_valid) begin
            w_resp_go   = 1'b1;
         end
      end
      w_eff_idx = w_resp_mode ? (4'd15 - w_resp_rc[3:0]) : w_resp_rc[3:0];
   end

   // Key register, C/D halves and subkey buffer; never presented before
   // keys_ready, so they carry no reset
   always_ff @(posedge clk) begin
      if (w_accept_load)
         r_key <= bus.key;
      if (r_state == S_PC1)
         {r_c, r_d} <= pc1(r_key);
      if (r_state == S_GEN) begin
         r_c              <= w_c_rot;
         r_d              <= w_d_rot;
         r_buf[r_gen_idx] <= pc2({w_c_rot, w_d_rot});
      end
   end

   // Control FSM, status flags, response registers and pending slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_gen_idx    <= 4'd0;
         r_keys_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_valid      <= 1'b0;
         r_subkey     <= 48'd0;
         r_err        <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_rc    <= 5'd0;
         r_pend_mode  <= 1'b0;
      end else begin
         r_valid <= 1'b0;

         case (r_state)
            S_IDLE, S_READY: begin
               if (bus.load_key) begin
                  r_state      <= S_PC1;
                  r_keys_ready <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_PC1: begin
               r_gen_idx <= 4'd0;
               r_state   <= S_GEN;
            end
            S_GEN: begin
               r_gen_idx <= r_gen_idx + 4'd1;
               if (r_gen_idx == 4'd15) begin
                  r_state      <= S_READY;
                  r_keys_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_resp_go) begin
            r_valid      <= 1'b1;
            r_err        <= w_resp_rc[4];
            r_subkey     <= w_resp_rc[4] ? 48'd0 : r_buf[w_eff_idx];
            r_pend_valid <= 1'b0;
         end else if (bus.subkey_req) begin
            r_pend_valid <= 1'b1;
            r_pend_rc    <= bus.round_counter;
            r_pend_mode  <= bus.mode;
         end
      end
   end

   assign bus.keys_ready   = r_keys_ready;
   assign bus.busy         = r_busy;
   assign bus.subkey_valid = r_valid;
   assign bus.subkey       = r_subkey;
   assign bus.subkey_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule_responder.sv
// ============================================================================
// Module      : tb_des_key_schedule_responder
// Description : Directed bench for the DES key schedule responder with a
//               response scoreboard and known-answer subkeys.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_key_schedule_responder;

   localparam logic [63:0] c_key_a    = 64'h133457799BBCDFF1;
   localparam logic [63:0] c_key_ones = 64'hFEFEFEFEFEFEFEFE;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   des_key_schedule_responder_if bus();

   des_key_schedule_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Published subkeys K1..K16 of key 133457799BBCDFF1
   logic [47:0] kexp [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   logic [47:0] sched [16];
   logic [48:0] sb [$];
   int vectors     = 0;
   int miscompares = 0;
   int n;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic use_key_a();
      for (int i = 0; i < 16; i++) sched[i] = kexp[i];
   endtask

   task automatic use_key_ones();
      for (int i = 0; i < 16; i++) sched[i] = 48'hFFFFFFFFFFFF;
   endtask

   function automatic logic [48:0] expect_of(input int rc, input bit m);
      if (rc >= 16) return {1'b1, 48'h0};
      return {1'b0, sched[m ? 15 - rc : rc]};
   endfunction

   task automatic drive_req(input int rc, input bit m);
      bus.subkey_req    = 1'b1;
      bus.round_counter = 5'(rc);
      bus.mode          = m;
   endtask

   task automatic issue(input int rc, input bit m);
      drive_req(rc, m);
      sb.push_back(expect_of(rc, m));
   endtask

   task automatic do_load(input logic [63:0] k);
      bus.load_key = 1'b1;
      bus.key      = k;
      tick();
      bus.load_key = 1'b0;
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (!bus.keys_ready && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   // Scoreboard: every response pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (bus.subkey_valid) begin
         if (sb.size() == 0)
            check("unexpected_pulse", {63'd0, bus.subkey_valid}, 64'd0);
         else
            check("sb_response", {15'd0, bus.subkey_err, bus.subkey}, {15'd0, sb.pop_front()});
      end
   end

   // Hard stop if the sequence never completes
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bus.load_key      = 1'b0;
      bus.key           = 64'd0;
      bus.subkey_req    = 1'b0;
      bus.round_counter = 5'd0;
      bus.mode          = 1'b0;
      use_key_a();
      repeat (3) tick();
      check("rst_keys_ready", {63'd0, bus.keys_ready}, 64'd0);
      check("rst_busy",       {63'd0, bus.busy},       64'd0);
      check("rst_valid",      {63'd0, bus.subkey_valid}, 64'd0);
      check("rst_subkey",     {16'd0, bus.subkey},     64'd0);
      rst_n = 1'b1;
      tick();

      // Basic load and latency
      do_load(c_key_a);
      check("busy_after_load",  {63'd0, bus.busy},       64'd1);
      check("ready_after_load", {63'd0, bus.keys_ready}, 64'd0);
      wait_ready(n);
      check("load_latency", 64'(n), 64'd17);
      check("busy_when_ready", {63'd0, bus.busy}, 64'd0);

      // Known answers in both directions, back to back
      issue(0, 1'b0);
      tick();
      check("resp_latency_valid", {63'd0, bus.subkey_valid}, 64'd1);
      check("k1_enc", {16'd0, bus.subkey}, 64'h1B02EFFC7072);
      issue(15, 1'b0);
      tick();
      check("k16_enc", {16'd0, bus.subkey}, 64'hCB3D8B0E17F5);
      issue(0, 1'b1);
      tick();
      check("k16_dec", {16'd0, bus.subkey}, 64'hCB3D8B0E17F5);
      issue(15, 1'b1);
      tick();
      check("k1_dec", {16'd0, bus.subkey}, 64'h1B02EFFC7072);
      bus.subkey_req = 1'b0;
      tick();
      check("pulse_ends", {63'd0, bus.subkey_valid}, 64'd0);
      tick();
      check("subkey_hold", {16'd0, bus.subkey}, 64'h1B02EFFC7072);

      // Full sweep on consecutive cycles
      for (int i = 0; i < 16; i++) begin
         issue(i, 1'b0);
         tick();
         check($sformatf("sweep_valid_%0d", i), {63'd0, bus.subkey_valid}, 64'd1);
      end
      bus.subkey_req = 1'b0;
      tick();

      // Out-of-range round numbers
      issue(20, 1'b0);
      tick();
      check("rc20_err",    {63'd0, bus.subkey_err}, 64'd1);
      check("rc20_subkey", {16'd0, bus.subkey},     64'd0);
      issue(31, 1'b1);
      tick();
      bus.subkey_req = 1'b0;
      tick();

      // Requests during generation; parity bits of the key must not matter
      do_load(c_key_a ^ 64'h0101010101010101);
      repeat (4) tick();
      drive_req(5, 1'b0);
      tick();
      issue(3, 1'b0);
      tick();
      bus.subkey_req = 1'b0;
      wait_ready(n);
      check("ready_with_pending", {63'd0, bus.keys_ready}, 64'd1);
      check("no_early_pulse", {63'd0, bus.subkey_valid}, 64'd0);
      tick();
      check("pending_valid",  {63'd0, bus.subkey_valid}, 64'd1);
      check("pending_subkey", {16'd0, bus.subkey}, {16'd0, kexp[3]});
      tick();
      check("pending_single", {63'd0, bus.subkey_valid}, 64'd0);

      // Load during GEN ignored; new request on the service edge replaces pending
      do_load(c_key_a);
      repeat (2) tick();
      drive_req(1, 1'b0);
      tick();
      bus.subkey_req = 1'b0;
      bus.load_key   = 1'b1;
      bus.key        = c_key_ones;
      tick();
      bus.load_key   = 1'b0;
      wait_ready(n);
      check("gen_ignores_load", 64'(n), 64'd13);
      issue(9, 1'b0);
      tick();
      check("replace_valid",  {63'd0, bus.subkey_valid}, 64'd1);
      check("replace_subkey", {16'd0, bus.subkey}, {16'd0, kexp[9]});
      bus.subkey_req = 1'b0;
      tick();
      check("replace_single", {63'd0, bus.subkey_valid}, 64'd0);

      // Load and request together in READY with a new key
      use_key_ones();
      bus.load_key = 1'b1;
      bus.key      = c_key_ones;
      issue(0, 1'b0);
      tick();
      bus.load_key   = 1'b0;
      bus.subkey_req = 1'b0;
      check("reload_drops_ready", {63'd0, bus.keys_ready}, 64'd0);
      check("reload_busy",        {63'd0, bus.busy},       64'd1);
      check("reload_no_pulse",    {63'd0, bus.subkey_valid}, 64'd0);
      wait_ready(n);
      check("reload_latency", 64'(n), 64'd17);
      tick();
      check("reload_valid",  {63'd0, bus.subkey_valid}, 64'd1);
      check("reload_subkey", {16'd0, bus.subkey}, 64'hFFFFFFFFFFFF);

      // Asynchronous reset in the middle of generation
      use_key_a();
      do_load(c_key_a);
      repeat (8) tick();
      drive_req(2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_keys_ready", {63'd0, bus.keys_ready},   64'd0);
      check("arst_busy",       {63'd0, bus.busy},         64'd0);
      check("arst_valid",      {63'd0, bus.subkey_valid}, 64'd0);
      check("arst_subkey",     {16'd0, bus.subkey},       64'd0);
      check("arst_err",        {63'd0, bus.subkey_err},   64'd0);
      bus.subkey_req = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("post_rst_idle_ready", {63'd0, bus.keys_ready}, 64'd0);
      check("post_rst_idle_busy",  {63'd0, bus.busy},       64'd0);
      do_load(c_key_a);
      wait_ready(n);
      check("post_rst_latency", 64'(n), 64'd17);
      issue(8, 1'b1);
      tick();
      check("post_rst_subkey", {16'd0, bus.subkey}, {16'd0, kexp[7]});
      bus.subkey_req = 1'b0;
      repeat (2) tick();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
